// File: rtl/circular_fifo_param.sv
// Parametrised single-clock circular FIFO: any depth, registered or FWFT read,
// programmable almost-full/almost-empty levels, sticky error flags and flush.
module circular_fifo_param #(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int FWFT     = 0,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         wr_en,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic                         rd_en,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         rd_valid,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow,
    output logic                         underflow,
    input  logic                         clr_err
);

    localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [PW-1:0]    w_wr_ptr_inc;
    logic [PW-1:0]    w_rd_ptr_inc;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic             r_empty;
    logic             r_full;
    logic             r_almost_full;
    logic             r_almost_empty;
    logic             r_overflow;
    logic             r_underflow;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_ovf_set;
    logic             w_unf_set;

    // Flush swallows both requests, so neither side can accept or raise an error.
    assign w_rd_acc  = !flush && rd_en && !r_empty;
    assign w_wr_acc  = !flush && wr_en && (!r_full || w_rd_acc);
    assign w_ovf_set = !flush && wr_en && !w_wr_acc;
    assign w_unf_set = !flush && rd_en && r_empty;

    // Explicit wrap so non-power-of-two depths work.
    assign w_wr_ptr_inc = (r_wr_ptr == PW'(DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_inc = (r_rd_ptr == PW'(DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

    // NOTE: always_comb assigns a default first so no path can infer a latch.
    always_comb begin
        w_count_nxt = r_count;
        if (flush) begin
            w_count_nxt = '0;
        end else if (w_wr_acc && !w_rd_acc) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_rd_acc && !w_wr_acc) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_empty        <= 1'b1;
            r_full         <= 1'b0;
            r_almost_full  <= 1'b0;
            r_almost_empty <= 1'b1;
            r_overflow     <= 1'b0;
            r_underflow    <= 1'b0;
        end else begin
            if (flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= w_wr_ptr_inc;
                if (w_rd_acc) r_rd_ptr <= w_rd_ptr_inc;
            end
            // Flags come from the next count so they always agree with count.
            r_count        <= w_count_nxt;
            r_empty        <= (w_count_nxt == '0);
            r_full         <= (w_count_nxt == CW'(DEPTH));
            r_almost_full  <= (w_count_nxt >= CW'(AF_LEVEL));
            r_almost_empty <= (w_count_nxt <= CW'(AE_LEVEL));

            if (w_ovf_set)    r_overflow  <= 1'b1;
            else if (clr_err) r_overflow  <= 1'b0;
            if (w_unf_set)    r_underflow <= 1'b1;
            else if (clr_err) r_underflow <= 1'b0;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr] <= wr_data;
    end

    generate
        if (FWFT == 0) begin : g_reg_read
            logic [WIDTH-1:0] r_rd_data;
            logic             r_rd_valid;

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_rd_data  <= '0;
                    r_rd_valid <= 1'b0;
                end else begin
                    r_rd_valid <= w_rd_acc;
                    if (w_rd_acc) r_rd_data <= r_mem[r_rd_ptr];
                end
            end

            assign rd_data  = r_rd_data;
            assign rd_valid = r_rd_valid;
        end else begin : g_fwft_read
            // Head word is shown directly; forced to zero while empty so reset reads 0.
            assign rd_data  = r_empty ? '0 : r_mem[r_rd_ptr];
            assign rd_valid = !r_empty;
        end
    endgenerate

    assign count        = r_count;
    assign empty        = r_empty;
    assign full         = r_full;
    assign almost_full  = r_almost_full;
    assign almost_empty = r_almost_empty;
    assign overflow     = r_overflow;
    assign underflow    = r_underflow;

endmodule

// File: tb/tb_circular_fifo_param.sv
// Bench for circular_fifo_param: a DEPTH=6 registered-read instance and a
// DEPTH=16 FWFT instance, each compared against a queue-based reference model.
module tb_circular_fifo_param;

    logic clk;
    logic reset;

    // Instance A: DEPTH=6, FWFT=0, AF_LEVEL=4, AE_LEVEL=1
    logic       a_flush, a_wr_en, a_rd_en, a_clr_err;
    logic [7:0] a_wr_data, a_rd_data;
    logic       a_rd_valid, a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [2:0] a_count;

    // Instance B: DEPTH=16, FWFT=1, AF_LEVEL=14, AE_LEVEL=2
    logic       b_flush, b_wr_en, b_rd_en, b_clr_err;
    logic [7:0] b_wr_data, b_rd_data;
    logic       b_rd_valid, b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [4:0] b_count;

    circular_fifo_param #(.WIDTH(8), .DEPTH(6), .FWFT(0), .AF_LEVEL(4), .AE_LEVEL(1)) u_a (
        .clk(clk), .reset(reset), .flush(a_flush), .wr_en(a_wr_en), .wr_data(a_wr_data),
        .rd_en(a_rd_en), .rd_data(a_rd_data), .rd_valid(a_rd_valid), .full(a_full),
        .empty(a_empty), .almost_full(a_af), .almost_empty(a_ae), .count(a_count),
        .overflow(a_ovf), .underflow(a_unf), .clr_err(a_clr_err)
    );

    circular_fifo_param #(.WIDTH(8), .DEPTH(16), .FWFT(1), .AF_LEVEL(14), .AE_LEVEL(2)) u_b (
        .clk(clk), .reset(reset), .flush(b_flush), .wr_en(b_wr_en), .wr_data(b_wr_data),
        .rd_en(b_rd_en), .rd_data(b_rd_data), .rd_valid(b_rd_valid), .full(b_full),
        .empty(b_empty), .almost_full(b_af), .almost_empty(b_ae), .count(b_count),
        .overflow(b_ovf), .underflow(b_unf), .clr_err(b_clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: plain queues plus the sticky flags and A's read register.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         m_ovf [2];
    bit         m_unf [2];
    logic [7:0] m_a_rdata;
    bit         m_a_rvalid;

    localparam logic [19:0] RESET_STATUS = {5'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

    function automatic logic [19:0] exp_status(input int inst);
        int n, depth, af, ae;
        bit v;
        logic [7:0] d;
        n     = (inst == 0) ? qa.size() : qb.size();
        depth = (inst == 0) ? 6 : 16;
        af    = (inst == 0) ? 4 : 14;
        ae    = (inst == 0) ? 1 : 2;
        if (inst == 0) begin
            v = m_a_rvalid;
            d = m_a_rdata;
        end else begin
            v = (n > 0);
            d = v ? qb[0] : 8'h00;
        end
        return {5'(n), n == 0, n == depth, n >= af, n <= ae, m_ovf[inst], m_unf[inst], v, d};
    endfunction

    function automatic logic [19:0] obs_status(input int inst);
        if (inst == 0)
            return {2'b00, a_count, a_empty, a_full, a_af, a_ae, a_ovf, a_unf, a_rd_valid, a_rd_data};
        return {b_count, b_empty, b_full, b_af, b_ae, b_ovf, b_unf, b_rd_valid,
                b_rd_valid ? b_rd_data : 8'h00};
    endfunction

    task automatic model_reset();
        qa.delete();
        qb.delete();
        for (int i = 0; i < 2; i++) begin
            m_ovf[i] = 1'b0;
            m_unf[i] = 1'b0;
        end
        m_a_rdata  = 8'h00;
        m_a_rvalid = 1'b0;
    endtask

    task automatic model_step(input int inst, input bit fl, input bit we, input bit re,
                              input bit ce, input logic [7:0] wd);
        int n, depth;
        bit racc, wacc;
        n     = (inst == 0) ? qa.size() : qb.size();
        depth = (inst == 0) ? 6 : 16;
        if (fl) begin
            if (inst == 0) begin
                qa.delete();
                m_a_rvalid = 1'b0;
            end else begin
                qb.delete();
            end
            if (ce) begin
                m_ovf[inst] = 1'b0;
                m_unf[inst] = 1'b0;
            end
        end else begin
            racc = re && (n > 0);
            wacc = we && ((n < depth) || racc);
            m_ovf[inst] = (we && !wacc) ? 1'b1 : (ce ? 1'b0 : m_ovf[inst]);
            m_unf[inst] = (re && n == 0) ? 1'b1 : (ce ? 1'b0 : m_unf[inst]);
            if (inst == 0) begin
                if (racc) m_a_rdata = qa.pop_front();
                m_a_rvalid = racc;
                if (wacc) qa.push_back(wd);
            end else begin
                if (racc) void'(qb.pop_front());
                if (wacc) qb.push_back(wd);
            end
        end
    endtask

    task automatic idle_inputs();
        {a_flush, a_wr_en, a_rd_en, a_clr_err} = 4'b0;
        {b_flush, b_wr_en, b_rd_en, b_clr_err} = 4'b0;
        a_wr_data = 8'h00;
        b_wr_data = 8'h00;
    endtask

    // Drives one cycle on the chosen instance (the other idles), advances the
    // model, and returns observed and expected status sampled 1 time unit after the edge.
    task automatic apply(input int inst, input bit fl, input bit we, input bit re, input bit ce,
                         input logic [7:0] wd, output logic [19:0] obs, output logic [19:0] exp);
        idle_inputs();
        if (inst == 0) begin
            {a_flush, a_wr_en, a_rd_en, a_clr_err} = {fl, we, re, ce};
            a_wr_data = wd;
        end else begin
            {b_flush, b_wr_en, b_rd_en, b_clr_err} = {fl, we, re, ce};
            b_wr_data = wd;
        end
        model_step(0, a_flush, a_wr_en, a_rd_en, a_clr_err, a_wr_data);
        model_step(1, b_flush, b_wr_en, b_rd_en, b_clr_err, b_wr_data);
        @(posedge clk);
        #1;
        obs = obs_status(inst);
        exp = exp_status(inst);
        idle_inputs();
    endtask

    task automatic test_reset();
        logic [19:0] o;
        for (int i = 0; i < 2; i++) begin
            o = obs_status(i);
            n_vec++;
            if (o !== RESET_STATUS) begin
                n_err++; $display("FAIL reset_state inst%0d: got %h expected %h", i, o, RESET_STATUS);
            end
        end
    endtask

    task automatic test_fill_overflow();
        logic [19:0] o, e;
        logic [7:0]  d;
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 1, 0, 0, 8'h10 + 8'(i), o, e);
            n_vec++; if (o !== e) begin n_err++; $display("FAIL fill: got %h expected %h", o, e); end
        end
        n_vec++;
        if (a_full !== 1'b1 || a_count !== 3'd6) begin
            n_err++; $display("FAIL full_at_6: got full=%b count=%0d expected full=1 count=6", a_full, a_count);
        end
        apply(0, 0, 1, 0, 0, 8'h99, o, e);
        n_vec++; if (o !== e) begin n_err++; $display("FAIL overflow: got %h expected %h", o, e); end
        n_vec++;
        if (a_ovf !== 1'b1 || a_count !== 3'd6) begin
            n_err++; $display("FAIL overflow_flag: got ovf=%b count=%0d expected ovf=1 count=6", a_ovf, a_count);
        end
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 0, 1, 0, 8'h00, o, e);
            d = 8'h10 + 8'(i);
            n_vec++;
            if (o !== e || a_rd_data !== d || a_rd_valid !== 1'b1) begin
                n_err++; $display("FAIL read_order: got %h data=%h expected %h data=%h", o, a_rd_data, e, d);
            end
        end
        apply(0, 0, 0, 0, 1, 8'h00, o, e);
        n_vec++; if (o !== e) begin n_err++; $display("FAIL clr_ovf: got %h expected %h", o, e); end
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 1, 0, 0, 8'h20 + 8'(i), o, e);
            n_vec++; if (o !== e) begin n_err++; $display("FAIL wrap_write: got %h expected %h", o, e); end
        end
        for (int i = 0; i < 4; i++) begin
            apply(0, 0, 0, 1, 0, 8'h00, o, e);
            d = 8'h20 + 8'(i);
            n_vec++;
            if (o !== e || a_rd_data !== d) begin
                n_err++; $display("FAIL wrap_read: got %h data=%h expected %h data=%h", o, a_rd_data, e, d);
            end
        end
    endtask

    task automatic test_write_through();
        logic [19:0] o, e;
        for (int i = 0; i < 6; i++) apply(0, 0, 1, 0, 0, 8'h30 + 8'(i), o, e);
        apply(0, 0, 1, 1, 0, 8'hAA, o, e);
        n_vec++; if (o !== e) begin n_err++; $display("FAIL write_through: got %h expected %h", o, e); end
        n_vec++;
        if (a_rd_data !== 8'h30 || a_count !== 3'd6 || a_full !== 1'b1 || a_ovf !== 1'b0) begin
            n_err++; $display("FAIL write_through_flags: got data=%h count=%0d full=%b ovf=%b expected 30/6/1/0",
                              a_rd_data, a_count, a_full, a_ovf);
        end
        for (int i = 0; i < 6; i++) begin
            apply(0, 0, 0, 1, 0, 8'h00, o, e);
            n_vec++; if (o !== e) begin n_err++; $display("FAIL drain: got %h expected %h", o, e); end
        end
    endtask

    task automatic test_underflow();
        logic [19:0] o, e;
        apply(0, 0, 0, 1, 0, 8'h00, o, e);
        n_vec++;
        if (o !== e || a_unf !== 1'b1 || a_count !== 3'd0) begin
            n_err++; $display("FAIL underflow: got %h unf=%b expected %h unf=1", o, a_unf, e);
        end
        apply(0, 0, 0, 0, 1, 8'h00, o, e);
        n_vec++;
        if (o !== e || a_unf !== 1'b0) begin
            n_err++; $display("FAIL clr_unf: got %h unf=%b expected %h unf=0", o, a_unf, e);
        end
        apply(0, 0, 0, 1, 1, 8'h00, o, e);
        n_vec++;
        if (o !== e || a_unf !== 1'b1) begin
            n_err++; $display("FAIL set_wins: got %h unf=%b expected %h unf=1", o, a_unf, e);
        end
        apply(0, 0, 0, 0, 1, 8'h00, o, e);
    endtask

    task automatic test_fwft();
        logic [19:0] o, e;
        apply(1, 0, 1, 0, 0, 8'h5A, o, e);
        n_vec++;
        if (o !== e || b_rd_valid !== 1'b1 || b_rd_data !== 8'h5A) begin
            n_err++; $display("FAIL fwft_show: got valid=%b data=%h expected valid=1 data=5a", b_rd_valid, b_rd_data);
        end
        apply(1, 0, 0, 1, 0, 8'h00, o, e);
        n_vec++;
        if (o !== e || b_rd_valid !== 1'b0 || b_empty !== 1'b1) begin
            n_err++; $display("FAIL fwft_pop: got valid=%b empty=%b expected valid=0 empty=1", b_rd_valid, b_empty);
        end
    endtask

    task automatic test_thresholds();
        logic [19:0] o, e;
        for (int i = 1; i <= 16; i++) begin
            apply(1, 0, 1, 0, 0, 8'(i * 7), o, e);
            n_vec++;
            if (o !== e || b_ae !== (i <= 2) || b_af !== (i >= 14)) begin
                n_err++; $display("FAIL thresholds count=%0d: got ae=%b af=%b expected ae=%b af=%b",
                                  i, b_ae, b_af, (i <= 2), (i >= 14));
            end
        end
        for (int i = 0; i < 6; i++) apply(1, 0, 0, 1, 0, 8'h00, o, e);
        apply(1, 1, 1, 0, 0, 8'hEE, o, e);
        n_vec++;
        if (o !== e || b_count !== 5'd0 || b_empty !== 1'b1 || b_ae !== 1'b1 || b_ovf !== 1'b0) begin
            n_err++; $display("FAIL flush: got count=%0d empty=%b ae=%b ovf=%b expected 0/1/1/0",
                              b_count, b_empty, b_ae, b_ovf);
        end
    endtask

    task automatic test_async_reset();
        logic [19:0] o, e;
        for (int i = 0; i < 5; i++) apply(0, 0, 1, 0, 0, 8'h40 + 8'(i), o, e);
        #3;
        reset = 1'b1;
        #1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            o = obs_status(i);
            n_vec++;
            if (o !== RESET_STATUS) begin
                n_err++; $display("FAIL async_reset inst%0d: got %h expected %h", i, o, RESET_STATUS);
            end
        end
        @(posedge clk);
        #2;
        reset = 1'b0;
        apply(0, 0, 1, 0, 0, 8'h77, o, e);
        apply(0, 0, 0, 1, 0, 8'h00, o, e);
        n_vec++;
        if (o !== e || a_rd_data !== 8'h77 || a_rd_valid !== 1'b1) begin
            n_err++; $display("FAIL post_reset_read: got data=%h valid=%b expected data=77 valid=1", a_rd_data, a_rd_valid);
        end
    endtask

    task automatic test_random();
        logic [19:0] o, e;
        int inst;
        for (int k = 0; k < 800; k++) begin
            inst = int'($urandom_range(0, 1));
            apply(inst, $urandom_range(0, 31) == 0, $urandom_range(0, 9) < 6,
                  $urandom_range(0, 9) < 5, $urandom_range(0, 15) == 0, 8'($urandom), o, e);
            n_vec++;
            if (o !== e) begin
                n_err++; $display("FAIL random inst%0d step %0d: got %h expected %h", inst, k, o, e);
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        reset = 1'b0;
        test_fill_overflow();
        test_write_through();
        test_underflow();
        test_fwft();
        test_thresholds();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/circular_fifo_param.md
Name: circular_fifo_param

Overview:
Parametrised circular FIFO for the SYSC datapath. It generalises the original single-mode 16x8 FIFO in several ways:
- arbitrary depth, including non-power-of-two
- selectable read mode: registered or first-word-fall-through (FWFT)
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- synchronous flush
- write-through when full, if a read is accepted in the same cycle

It sits between producer and consumer stages in the same clock domain.

Parameters:
- WIDTH, 8: data width in bits, >=1.
- DEPTH, 16: number of entries, >=2. Any integer is legal.
- FWFT, 0: read mode. 0 = registered read, data one cycle after the pop. 1 = head word visible while non-empty.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL. Range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL. Range 0..DEPTH-1.
- Derived localparams:
  - PW = max(1, $clog2(DEPTH)), the pointer width.
  - CW = $clog2(DEPTH+1), the count width.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- flush, input, 1: synchronous empty-the-FIFO command.
- wr_en, input, 1: write request.
- wr_data, input, WIDTH: write data.
- rd_en, input, 1: read/pop request.
- rd_data, output, WIDTH: read data.
- rd_valid, output, 1: rd_data is valid.
- full, output, 1: count == DEPTH.
- empty, output, 1: count == 0.
- almost_full, output, 1: count >= AF_LEVEL.
- almost_empty, output, 1: count <= AE_LEVEL.
- count, output, CW: current occupancy, 0..DEPTH.
- overflow, output, 1: sticky; a write was rejected.
- underflow, output, 1: sticky; a read was rejected.
- clr_err, input, 1: synchronous clear of overflow and underflow.

Behaviour:
- Reset is asynchronous and active-high. Reset values:
  - wr_ptr = rd_ptr = 0, count = 0
  - empty = 1, full = 0, almost_empty = 1
  - almost_full = 0
  - rd_data = 0, rd_valid = 0
  - overflow = underflow = 0
- Memory contents are not reset.
- A reset asserted mid-operation discards all data immediately; no partial transfer completes.
- Accept rules:
  - rd_acc = rd_en && !empty.
  - wr_acc = wr_en && (!full || rd_acc). Write-through when full is allowed only with a simultaneous accepted read.
- Pointers increment on accept and wrap by explicit compare: DEPTH-1 -> 0. Modulo on a power of two is not allowed.
- Count update:
  - +1 on wr_acc only
  - -1 on rd_acc only
  - unchanged when both accept or when neither accepts
- All flags are registered and computed from the next-state count, so they are valid in the same cycle as count. There are no combinational flag paths.
- Simultaneous read and write when empty: the read is rejected (underflow sets). The write is accepted, and count = 1 next cycle.
- FWFT=0 (registered read):
  - On rd_acc, rd_data <= mem[rd_ptr] and rd_valid = 1 for exactly the next cycle; otherwise rd_valid = 0.
  - rd_data holds its last value when no read is accepted.
- FWFT=1 (first-word-fall-through):
  - rd_data = mem[rd_ptr] and rd_valid = !empty.
  - A write into an empty FIFO appears on rd_data with rd_valid = 1 in the cycle after the write edge.
  - rd_en pops the head; the next word, if present, is visible after that edge.
- Error flags:
  - overflow sets on (wr_en && !wr_acc).
  - underflow sets on (rd_en && empty).
  - Both hold until clr_err or reset. If set and clr_err occur in the same cycle, set wins.
- flush:
  - Priority over wr_en and rd_en in that cycle; both requests are ignored and raise no errors.
  - Next cycle: pointers = 0, count = 0, empty = 1, full = 0, almost flags recomputed, rd_valid = 0.
  - rd_data and the error flags are unchanged.
- count and all flags must never disagree in any cycle.

Test Plan:
- DEPTH=6, FWFT=0: write 0x10..0x15 -> full = 1 and count = 6 after the 6th edge. A 7th write sets overflow, count stays 6. Read 6 -> rd_data 0x10..0x15, each one cycle after its rd_en. Then write 4 and read 4 more -> pointers wrap 5 -> 0 and data order is preserved.
- Full FIFO, wr_en = rd_en = 1 with wr_data = 0xAA -> the head is read, 0xAA is accepted, count stays DEPTH, full stays 1, overflow stays 0.
- Empty FIFO, rd_en = 1 -> underflow = 1 and count stays 0. Assert clr_err -> underflow = 0 next cycle. Assert rd_en and clr_err together while empty -> underflow stays 1.
- FWFT=1: write 0x5A into an empty FIFO -> rd_valid = 1 and rd_data = 0x5A in the next cycle, with no rd_en. Pop -> rd_valid = 0 and empty = 1.
- DEPTH=16, AF_LEVEL=14, AE_LEVEL=2:
  - Fill step by step -> almost_empty deasserts at count 3, almost_full asserts at count 14.
  - Flush at count 10 with wr_en high -> count = 0, empty = 1, almost_empty = 1, no overflow.
- Fill 5 words, assert reset asynchronously between clock edges -> all outputs go to their reset values immediately without a clock edge. The first write after reset is read back correctly.
